// File: rtl/or_accum_pkg.sv
// rtl/or_accum_pkg.sv - shared types and constants for the OR window accumulator
// Contents: state_t (ACCUM/HOLD), WINDOW legality bounds, cnt_width() helper.
package or_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int WINDOW_MIN = 1;
    localparam int WINDOW_MAX = 256;

    // Width of a counter that must hold the values 0..window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/or_window_accum.sv
// rtl/or_window_accum.sv - ORs WINDOW accepted samples into a sticky result behind a valid/ready port
// Parameters: WIDTH (sample/result width), WINDOW (samples per window, 1..256).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   I, I_valid        sample in;  I_ready  = sample accepted this cycle
//   O, O_count        closed-window OR result and number of samples folded in
//   O_valid, O_ready  result handshake
//   FLUSH             close a partial window early (only when OR_ACCUM_FLUSH_EN is defined)
module or_window_accum
    import or_accum_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int WINDOW = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [WIDTH-1:0]              I,
    input  logic                          I_valid,
    output logic                          I_ready,
    output logic [WIDTH-1:0]              O,
    output logic [cnt_width(WINDOW)-1:0]  O_count,
    output logic                          O_valid,
    input  logic                          O_ready
`ifdef OR_ACCUM_FLUSH_EN
    ,
    input  logic                          FLUSH
`endif
);

    localparam int             CW      = cnt_width(WINDOW);
    localparam logic [CW-1:0]  WIN_CNT = CW'(WINDOW);

    if (WINDOW < WINDOW_MIN || WINDOW > WINDOW_MAX) begin : g_bad_window
        $error("or_window_accum: illegal WINDOW value");
    end

    state_t            state;
    logic [WIDTH-1:0]  acc;
    logic [CW-1:0]     cnt;

    logic              in_xfer;
    logic              out_xfer;
    logic              flush_req;
    logic [WIDTH-1:0]  nacc;
    logic [CW-1:0]     ncnt;
    logic              close;

`ifdef OR_ACCUM_FLUSH_EN
    assign flush_req = FLUSH;
`else
    assign flush_req = 1'b0;
`endif

    // In HOLD the input can only move when the result leaves in the same cycle.
    assign I_ready  = (state == ACCUM) | O_ready;
    assign O_valid  = (state == HOLD);
    assign in_xfer  = I_valid & I_ready;
    assign out_xfer = O_valid & O_ready;

    // Window contents including any sample accepted this cycle.
    assign nacc  = acc | (in_xfer ? I : '0);
    assign ncnt  = cnt + CW'(in_xfer);
    // A flush only closes a window that holds at least one sample.
    assign close = (ncnt == WIN_CNT) | (flush_req & (ncnt != '0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            O       <= '0;
            O_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        O       <= nacc;
                        O_count <= ncnt;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= HOLD;
                    end else begin
                        acc <= nacc;
                        cnt <= ncnt;
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        if (in_xfer && WINDOW == 1) begin
                            // Single-sample windows close at once: reload and stay.
                            O       <= I;
                            O_count <= CW'(1);
                        end else if (in_xfer) begin
                            acc   <= I;
                            cnt   <= CW'(1);
                            state <= ACCUM;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_or_window_accum.sv
// tb/tb_or_window_accum.sv - self-checking bench for or_window_accum (WINDOW=4 and WINDOW=1 side by side)
module tb_or_window_accum;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic       flush;
    logic [1:0] i;

    logic       r4, v4;
    logic [1:0] o4;
    logic [2:0] c4;
    logic       r1, v1;
    logic [1:0] o1;
    logic [0:0] c1;

    or_window_accum #(.WIDTH(2), .WINDOW(4)) dut4 (
        .CLK(clk), .RESET(reset), .I(i), .I_valid(i_valid), .I_ready(r4),
        .O(o4), .O_count(c4), .O_valid(v4), .O_ready(o_ready)
`ifdef OR_ACCUM_FLUSH_EN
        , .FLUSH(flush)
`endif
    );

    or_window_accum #(.WIDTH(2), .WINDOW(1)) dut1 (
        .CLK(clk), .RESET(reset), .I(i), .I_valid(i_valid), .I_ready(r1),
        .O(o1), .O_count(c1), .O_valid(v1), .O_ready(o_ready)
`ifdef OR_ACCUM_FLUSH_EN
        , .FLUSH(flush)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] o;
        int         cnt;
    } res_t;

    res_t       q4[$];
    res_t       q1[$];
    bit         model_on = 1'b0;
    bit         m_hold[2];
    logic [1:0] m_acc[2];
    int         m_cnt[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input int d, input logic [1:0] o, input int cnt);
        res_t e;
        e.o   = o;
        e.cnt = cnt;
        if (d == 0) q4.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference behaviour for one DUT, evaluated just before the rising edge.
    task automatic model(input int d, input int w, input logic rdy, input logic vld,
                         input logic [1:0] o, input logic [15:0] c);
        logic want_rdy = !m_hold[d] || o_ready;
        logic in_x     = i_valid && want_rdy;
        logic out_x    = m_hold[d] && o_ready;
        res_t e;
        bit   got = 1'b0;
        string sfx = (d == 0) ? "w4" : "w1";
        chk({"i_ready_", sfx}, 16'(rdy), 16'(want_rdy));
        chk({"o_valid_", sfx}, 16'(vld), 16'(m_hold[d]));
        if (out_x) begin
            if (d == 0 && q4.size() > 0) begin e = q4.pop_front(); got = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            chk({"sb_have_", sfx}, 16'(got), 16'd1);
            if (got) begin
                chk({"sb_o_", sfx}, 16'(o), 16'(e.o));
                chk({"sb_cnt_", sfx}, c, 16'(e.cnt));
            end
        end
        if (reset) begin
            m_hold[d] = 1'b0;
            m_acc[d]  = 2'b00;
            m_cnt[d]  = 0;
            if (d == 0) q4.delete();
            else        q1.delete();
        end else if (!m_hold[d]) begin
            if (in_x) begin
                m_acc[d] = m_acc[d] | i;
                m_cnt[d] = m_cnt[d] + 1;
            end
            if (m_cnt[d] == w || (flush && m_cnt[d] > 0)) begin
                push(d, m_acc[d], m_cnt[d]);
                m_hold[d] = 1'b1;
                m_acc[d]  = 2'b00;
                m_cnt[d]  = 0;
            end
        end else if (out_x) begin
            if (in_x && w == 1) begin
                push(d, i, 1);
            end else if (in_x) begin
                m_hold[d] = 1'b0;
                m_acc[d]  = i;
                m_cnt[d]  = 1;
            end else begin
                m_hold[d] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_on) begin
            model(0, 4, r4, v4, o4, 16'(c4));
            model(1, 1, r1, v1, o1, 16'(c1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d);
        i_valid = v;
        i       = d;
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        flush   = 1'b0;
        i       = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_o",       16'(o4), 16'd0);
        chk("rst_count",   16'(c4), 16'd0);
        chk("rst_o_valid", 16'(v4), 16'd0);
        chk("rst_i_ready", 16'(r4), 16'd1);
        chk("rst_o_w1",    16'(o1), 16'd0);
        chk("rst_vld_w1",  16'(v1), 16'd0);
        for (int d = 0; d < 2; d++) begin
            m_hold[d] = 1'b0;
            m_acc[d]  = 2'b00;
            m_cnt[d]  = 0;
        end
        reset    = 1'b0;
        model_on = 1'b1;

        // Basic window: 01,00,00,10 -> 11 / 4, valid for exactly one cycle.
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b00);
        drive(1'b1, 2'b00);
        chk("basic_not_yet", 16'(v4), 16'd0);
        drive(1'b1, 2'b10);
        chk("basic_valid", 16'(v4), 16'd1);
        chk("basic_o",     16'(o4), 16'(2'b11));
        chk("basic_count", 16'(c4), 16'd4);
        drive(1'b0, 2'b00);
        chk("basic_one_cycle", 16'(v4), 16'd0);

        // Invalid cycles are not counted.
        for (int k = 0; k < 8; k++) begin
            drive(k[0], 2'b01);
            if (k == 6) chk("toggle_early", 16'(v4), 16'd0);
        end
        chk("toggle_valid", 16'(v4), 16'd1);
        chk("toggle_o",     16'(o4), 16'(2'b01));
        chk("toggle_count", 16'(c4), 16'd4);

        // Backpressure: result held, input stalled, then release with a new sample.
        for (int k = 0; k < 4; k++) drive(1'b1, 2'b01);
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b11);
            chk("bp_i_ready", 16'(r4), 16'd0);
            chk("bp_o",       16'(o4), 16'(2'b01));
            chk("bp_valid",   16'(v4), 16'd1);
        end
        o_ready = 1'b1;
        drive(1'b1, 2'b10);
        chk("bp_release", 16'(v4), 16'd0);
        for (int k = 0; k < 3; k++) drive(1'b1, 2'b00);
        chk("bp_next_o",     16'(o4), 16'(2'b10));
        chk("bp_next_count", 16'(c4), 16'd4);
        drive(1'b0, 2'b00);

        // WINDOW=1 full throughput.
        drive(1'b1, 2'b01);
        chk("w1_a_valid", 16'(v1), 16'd1);
        chk("w1_a_o",     16'(o1), 16'(2'b01));
        drive(1'b1, 2'b10);
        chk("w1_b_valid", 16'(v1), 16'd1);
        chk("w1_b_o",     16'(o1), 16'(2'b10));
        chk("w1_b_count", 16'(c1), 16'd1);
        drive(1'b1, 2'b11);
        chk("w1_c_valid", 16'(v1), 16'd1);
        chk("w1_c_o",     16'(o1), 16'(2'b11));
        drive(1'b1, 2'b00);
        drive(1'b0, 2'b00);

        // Reset mid-window discards the partial window.
        drive(1'b1, 2'b11);
        drive(1'b1, 2'b11);
        reset = 1'b1;
        drive(1'b0, 2'b00);
        reset = 1'b0;
        chk("midrst_valid", 16'(v4), 16'd0);
        chk("midrst_o",     16'(o4), 16'd0);
        chk("midrst_count", 16'(c4), 16'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 2'b00);
        chk("midrst_next_valid", 16'(v4), 16'd1);
        chk("midrst_next_o",     16'(o4), 16'(2'b00));
        chk("midrst_next_count", 16'(c4), 16'd4);
        drive(1'b0, 2'b00);

`ifdef OR_ACCUM_FLUSH_EN
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b00);
        drive(1'b1, 2'b10);
        flush = 1'b1;
        drive(1'b0, 2'b00);
        chk("flush_valid", 16'(v4), 16'd1);
        chk("flush_o",     16'(o4), 16'(2'b11));
        chk("flush_count", 16'(c4), 16'd3);
        drive(1'b0, 2'b00);
        chk("flush_in_hold", 16'(v4), 16'd0);
        drive(1'b0, 2'b00);
        chk("flush_empty", 16'(v4), 16'd0);
        flush = 1'b0;
`endif

        drive(1'b0, 2'b00);
        chk("drain_w4", 16'(q4.size()), 16'd0);
        chk("drain_w1", 16'(q1.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_window_accum.md
# or_window_accum

Sequential OR-accumulator directly downstream of the 4-lane, 2-bit OR-reduce stage. It consumes one OR-reduced word per accepted cycle and ORs WINDOW consecutive accepted samples into a sticky result. It presents that result on a valid/ready output port and applies backpressure upstream while the result is unaccepted. Typical use: turning per-cycle "any lane active" flags into per-window activity summaries.

## Interface
- WIDTH, 2, bit width of the sample and result (matches the OR-reduce stage output)
- WINDOW, 4, number of accepted samples per window; legal range 1..256
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- I  input  WIDTH  sample from the OR-reduce stage
- I_valid  input  1  sample on I is valid
- I_ready  output  1  block accepts I this cycle
- O  output  WIDTH  accumulated OR of the closed window
- O_count  output  $clog2(WINDOW+1)  number of samples folded into O
- O_valid  output  1  O/O_count hold a closed window
- O_ready  input  1  consumer accepts O this cycle
- FLUSH  input  1  close a partial window early (present only with OR_ACCUM_FLUSH_EN)

One clock; reset is synchronous and active-high, on ports CLK and RESET.

## Operation
- Transfer rules: input transfer = I_valid & I_ready; output transfer = O_valid & O_ready.
- States: ACCUM (gathering samples) and HOLD (result waiting for the consumer).
- Internal acc (WIDTH) and cnt ($clog2(WINDOW+1)) belong to the window being gathered.
- ACCUM:
  - I_ready=1, O_valid=0.
  - On input transfer: acc <= acc | I, cnt <= cnt+1.
  - If that transfer is the WINDOW-th sample: O <= acc|I, O_count <= WINDOW, acc <= 0, cnt <= 0, go to HOLD.
- HOLD:
  - O_valid=1; O and O_count stay stable until an output transfer.
  - I_ready = O_ready (pass-through), so the input stalls while the output is stalled.
  - On output transfer without input transfer: go to ACCUM.
  - On output transfer with simultaneous input transfer: the sample is the first of the next window (acc <= I, cnt <= 1), and the block goes to ACCUM.
  - Exception for WINDOW=1: every sample closes its window immediately. Output transfer plus input transfer reloads O <= I, O_count <= 1 and stays in HOLD. This gives full throughput with no bubble.
- Arithmetic:
  - OR is bitwise; there is no carry or saturation.
  - cnt never exceeds WINDOW.
  - Samples with I_valid=0 do not count.
- Reset mid-window or mid-HOLD:
  - The partial window and any pending result are discarded.
  - The block returns to ACCUM with acc=0, cnt=0.

## Timing
- Reset values: O=0, O_count=0, O_valid=0, I_ready=1 (ACCUM).
- Latency: O_valid rises on the cycle after the input transfer of the WINDOW-th sample (1-cycle registered output).
- Throughput:
  - WINDOW>1: steady state is one window per WINDOW cycles with no bubbles, provided O_ready is high when O_valid is.
  - WINDOW=1: one result per cycle.
- I_ready is combinational from O_ready in HOLD only; there are no other combinational input-to-output paths.
- O_valid, once high, never drops without an output transfer or RESET.

## Configuration
- OR_ACCUM_FLUSH_EN defined:
  - The FLUSH port exists.
  - FLUSH in ACCUM with cnt>0 (counting any same-cycle input transfer) closes the window next cycle. O = acc (including the sample), O_count = samples folded in.
  - FLUSH with an empty window and no transfer is ignored.
  - FLUSH in HOLD is ignored.
- OR_ACCUM_FLUSH_EN undefined: there is no FLUSH port, and windows close only on count.

## Structure
- Package or_accum_pkg contains:
  - state enum {ACCUM, HOLD};
  - function cnt_width(window) returning $clog2(window+1);
  - parameter legality check constants (WINDOW_MIN=1, WINDOW_MAX=256).
- Single flat module. No sub-module is warranted; the counter is inline.

## Test plan
- WINDOW=4, O_ready=1, I=01,00,00,10 consecutive valid -> O=11, O_count=4, O_valid for exactly one cycle, on the cycle after the 4th sample.
- WINDOW=4, I_valid toggling 1/0 with I=01 each valid cycle -> O=01 only after 4 valid samples (8 cycles); invalid cycles are not counted.
- WINDOW=4, O_ready=0 after the window closes, I_valid=1 -> I_ready=0 and O stable for 5 cycles. O_ready=1 with I=10 in the same cycle -> next window starts with acc=10, cnt=1.
- WINDOW=1, continuous I=01,10,11 with O_ready=1 -> O=01,10,11 on consecutive cycles with O_valid held high.
- RESET asserted after 2 of 4 samples (I=11) -> O_valid=0, O=0. The next 4 samples of 00 give O=00, O_count=4.
- With OR_ACCUM_FLUSH_EN: after 3 samples (01,00,10), FLUSH=1 -> O=11, O_count=3. FLUSH on an empty window produces no O_valid.
